// File: rtl/mqnic_app_cfg_ram_ctrl_pkg.sv
// Shared definitions for the app config RAM controller: register offsets within
// the 1 KiB window, command op codes, type ID, STATUS/CMD field positions, FSM states.
package mqnic_app_cfg_ram_ctrl_pkg;

    localparam logic [9:0]  REG_TYPE    = 10'h000;
    localparam logic [9:0]  REG_VER     = 10'h004;
    localparam logic [9:0]  REG_NEXT    = 10'h008;
    localparam logic [9:0]  REG_INFO    = 10'h00C;
    localparam logic [9:0]  REG_CMD     = 10'h010;
    localparam logic [9:0]  REG_STATUS  = 10'h014;

    localparam logic [31:0] TYPE_ID     = 32'h0000C002;

    localparam int STATUS_BUSY_BIT = 31;
    localparam int STATUS_ERR_BIT  = 30;
    localparam int FIELD_CH_LSB    = 16;
    localparam int CMD_OP_LSB      = 30;

    typedef enum logic [1:0] {
        OP_NONE   = 2'b00,
        OP_COMMIT = 2'b01,
        OP_FETCH  = 2'b10,
        OP_RSVD   = 2'b11
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMMIT,
        ST_FETCH_RD,
        ST_FETCH_WAIT
    } state_t;

    // Staging words live at 0x100..0x1FC; only word-aligned offsets decode.
    function automatic logic is_stage(input logic [9:0] off);
        return (off[9:8] == 2'b01) && (off[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mqnic_app_cfg_ram_ctrl_if.sv
// Host register bus (axil_reg_if style) between the register bridge and a block.
// master drives requests (addr/data/strb/en); slave returns wait/ack/read data.
interface mqnic_app_cfg_ram_ctrl_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic                  wr_en;
    logic                  wr_wait;
    logic                  wr_ack;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_wait;
    logic                  rd_ack;

    modport master (
        output wr_addr, wr_data, wr_strb, wr_en, rd_addr, rd_en,
        input  wr_wait, wr_ack, rd_data, rd_wait, rd_ack
    );

    modport slave (
        input  wr_addr, wr_data, wr_strb, wr_en, rd_addr, rd_en,
        output wr_wait, wr_ack, rd_data, rd_wait, rd_ack
    );
endinterface

// File: rtl/mqnic_app_cfg_ram_ctrl_tdpram.sv
// True dual-port config RAM for one channel.
// Port A: write (a_we) or read (a_re) at a_addr; Port B: read only.
// Both read ports have fixed RD_DLY latency; reads are read-first w.r.t. a same-cycle write.
// Ports: clk, a_we/a_re/a_addr/a_wdata/a_rdata, b_re/b_addr/b_rdata.
module mqnic_app_cfg_ram_ctrl_tdpram #(
    parameter int AW     = 4,
    parameter int DW     = 512,
    parameter int RD_DLY = 1
) (
    input  logic          clk,
    input  logic          a_we,
    input  logic          a_re,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic [DW-1:0] a_rdata,
    input  logic          b_re,
    input  logic [AW-1:0] b_addr,
    output logic [DW-1:0] b_rdata
);
    logic [DW-1:0] mem    [2**AW];
    logic [DW-1:0] a_pipe [RD_DLY];
    logic [DW-1:0] b_pipe [RD_DLY];

    always_ff @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_wdata;
        if (a_re) a_pipe[0] <= mem[a_addr];
        if (b_re) b_pipe[0] <= mem[b_addr];
        for (int unsigned i = 1; i < RD_DLY; i++) begin
            a_pipe[i] <= a_pipe[i-1];
            b_pipe[i] <= b_pipe[i-1];
        end
    end

    assign a_rdata = a_pipe[RD_DLY-1];
    assign b_rdata = b_pipe[RD_DLY-1];
endmodule

// File: rtl/mqnic_app_cfg_ram_ctrl.sv
// Host control/status regfile plus CH_COUNT per-channel wide config RAMs.
// The host assembles a RAM_DWIDTH entry in 32-bit staging words, then commits or
// fetches it by command; the data path has a read port and a priority write port.
// Ports: clk, rst_n (async, active low), reg_bus (slave register bus),
//        dp_ren/dp_raddr/dp_rdata (per-channel read), dp_wen/dp_waddr/dp_wdata
//        (per-channel write, wins over host), cfg_busy (host command in progress).
module mqnic_app_cfg_ram_ctrl
    import mqnic_app_cfg_ram_ctrl_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 16,
    parameter int          STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [5:0]  BLOCK_SEL  = 6'h0,
    parameter int          CH_COUNT   = 2,
    parameter int          RAM_AWIDTH = 4,
    parameter int          RAM_DWIDTH = 512,
    parameter int          RD_DLY     = 1,
    parameter logic [31:0] APP_VER    = 32'h20240301
) (
    input  logic                           clk,
    input  logic                           rst_n,
    mqnic_app_cfg_ram_ctrl_if.slave        reg_bus,
    input  logic [CH_COUNT-1:0]            dp_ren,
    input  logic [CH_COUNT*RAM_AWIDTH-1:0] dp_raddr,
    output logic [CH_COUNT*RAM_DWIDTH-1:0] dp_rdata,
    input  logic [CH_COUNT-1:0]            dp_wen,
    input  logic [CH_COUNT*RAM_AWIDTH-1:0] dp_waddr,
    input  logic [CH_COUNT*RAM_DWIDTH-1:0] dp_wdata,
    output logic                           cfg_busy
);
    localparam int WORDS = RAM_DWIDTH / 32;
    localparam int CNT_W = (RD_DLY > 1) ? $clog2(RD_DLY) : 1;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic                  commit_we, fetch_re, fetch_latch;
    logic                  cmd_go, err, busy, wen_hit;
    cmd_op_t               cmd_op;
    logic [3:0]            cmd_ch;
    logic [RAM_AWIDTH-1:0] cmd_idx;
    logic [RAM_DWIDTH-1:0] staging, fetch_data;
    logic [CH_COUNT-1:0]   ch_sel;
    logic [RAM_DWIDTH-1:0] q_a [CH_COUNT];

    logic [9:0]            wr_off, rd_off;
    logic [5:0]            wr_k, rd_k;
    logic                  wr_hit, rd_hit, stage_wr, stage_rd;
    cmd_op_t               wr_op;
    logic [3:0]            wr_ch;
    logic                  op_valid, cmd_bad;
    logic [DATA_WIDTH-1:0] rd_word;

    assign wr_off   = reg_bus.wr_addr[9:0];
    assign rd_off   = reg_bus.rd_addr[9:0];
    // Gating on our own ack drops a repeated en that overlaps its ack cycle.
    assign wr_hit   = reg_bus.wr_en && (reg_bus.wr_addr[ADDR_WIDTH-1 -: 6] == BLOCK_SEL) && !reg_bus.wr_ack;
    assign rd_hit   = reg_bus.rd_en && (reg_bus.rd_addr[ADDR_WIDTH-1 -: 6] == BLOCK_SEL) && !reg_bus.rd_ack;
    assign wr_k     = wr_off[7:2];
    assign rd_k     = rd_off[7:2];
    assign stage_wr = is_stage(wr_off) && ({26'd0, wr_k} < 32'(WORDS));
    assign stage_rd = is_stage(rd_off) && ({26'd0, rd_k} < 32'(WORDS));

    assign wr_op    = cmd_op_t'(reg_bus.wr_data[CMD_OP_LSB +: 2]);
    assign wr_ch    = reg_bus.wr_data[FIELD_CH_LSB +: 4];
    assign op_valid = (wr_op == OP_COMMIT) || (wr_op == OP_FETCH);
    // A command accepted last cycle but not yet seen by the FSM also counts as busy.
    assign busy     = (state != ST_IDLE) || cmd_go;
    assign cmd_bad  = busy || ({28'd0, wr_ch} >= 32'(CH_COUNT));
    assign cfg_busy = busy;

    assign reg_bus.wr_wait = 1'b0;
    assign reg_bus.rd_wait = 1'b0;

    always_comb begin
        rd_word = '0;
        case (rd_off)
            REG_TYPE:   rd_word = TYPE_ID;
            REG_VER:    rd_word = APP_VER;
            REG_NEXT:   rd_word = '0;
            REG_INFO:   rd_word = {8'(CH_COUNT), 8'(RAM_AWIDTH), 16'(WORDS)};
            REG_STATUS: begin
                rd_word[STATUS_BUSY_BIT]        = busy;
                rd_word[STATUS_ERR_BIT]         = err;
                rd_word[FIELD_CH_LSB +: 4]      = cmd_ch;
                rd_word[RAM_AWIDTH-1:0]         = cmd_idx;
            end
            default:    if (stage_rd) rd_word = staging[32*rd_k +: 32];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_bus.wr_ack  <= 1'b0;
            reg_bus.rd_ack  <= 1'b0;
            reg_bus.rd_data <= '0;
            cmd_go          <= 1'b0;
            cmd_op          <= OP_NONE;
            cmd_ch          <= '0;
            cmd_idx         <= '0;
            err             <= 1'b0;
            staging         <= '0;
        end else begin
            reg_bus.wr_ack <= wr_hit;
            reg_bus.rd_ack <= rd_hit;
            if (state == ST_IDLE) cmd_go <= 1'b0;
            if (wr_hit) begin
                if (wr_off == REG_CMD && op_valid) begin
                    if (cmd_bad) begin
                        err <= 1'b1;
                    end else begin
                        cmd_go  <= 1'b1;
                        cmd_op  <= wr_op;
                        cmd_ch  <= wr_ch;
                        cmd_idx <= reg_bus.wr_data[RAM_AWIDTH-1:0];
                    end
                end
                if (wr_off == REG_STATUS && reg_bus.wr_data[STATUS_ERR_BIT]) err <= 1'b0;
                if (stage_wr) begin
                    for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
                        if (reg_bus.wr_strb[b]) staging[32*wr_k + 8*b +: 8] <= reg_bus.wr_data[8*b +: 8];
                    end
                end
            end
            // Fetched data lands after any same-cycle host staging write.
            if (fetch_latch) staging <= fetch_data;
            if (rd_hit) reg_bus.rd_data <= rd_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        commit_we   = 1'b0;
        fetch_re    = 1'b0;
        fetch_latch = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_go) state_next = (cmd_op == OP_FETCH) ? ST_FETCH_RD : ST_COMMIT;
            end
            ST_COMMIT: begin
                if (!wen_hit) begin
                    commit_we  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_FETCH_RD: begin
                if (!wen_hit) begin
                    fetch_re   = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_FETCH_WAIT;
                end
            end
            ST_FETCH_WAIT: begin
                if (cnt == CNT_W'(RD_DLY - 1)) begin
                    fetch_latch = 1'b1;
                    state_next  = ST_IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        fetch_data = '0;
        for (int unsigned c = 0; c < CH_COUNT; c++) begin
            if (ch_sel[c]) fetch_data = q_a[c];
        end
    end

    assign wen_hit = |(dp_wen & ch_sel);

    for (genvar c = 0; c < CH_COUNT; c++) begin : g_ch
        logic                  a_we, a_re;
        logic [RAM_AWIDTH-1:0] a_addr;
        logic [RAM_DWIDTH-1:0] a_wdata;

        assign ch_sel[c] = (cmd_ch == 4'(c));
        assign a_we      = dp_wen[c] | (commit_we & ch_sel[c]);
        assign a_re      = fetch_re & ch_sel[c];
        assign a_addr    = dp_wen[c] ? dp_waddr[c*RAM_AWIDTH +: RAM_AWIDTH] : cmd_idx;
        assign a_wdata   = dp_wen[c] ? dp_wdata[c*RAM_DWIDTH +: RAM_DWIDTH] : staging;

        mqnic_app_cfg_ram_ctrl_tdpram #(
            .AW     (RAM_AWIDTH),
            .DW     (RAM_DWIDTH),
            .RD_DLY (RD_DLY)
        ) u_ram (
            .clk     (clk),
            .a_we    (a_we),
            .a_re    (a_re),
            .a_addr  (a_addr),
            .a_wdata (a_wdata),
            .a_rdata (q_a[c]),
            .b_re    (dp_ren[c]),
            .b_addr  (dp_raddr[c*RAM_AWIDTH +: RAM_AWIDTH]),
            .b_rdata (dp_rdata[c*RAM_DWIDTH +: RAM_DWIDTH])
        );
    end
endmodule

// File: tb/tb_mqnic_app_cfg_ram_ctrl.sv
// Directed bench for mqnic_app_cfg_ram_ctrl (CH_COUNT=2, RAM_AWIDTH=4, RAM_DWIDTH=512, RD_DLY=1).
module tb_mqnic_app_cfg_ram_ctrl;
    localparam int          WORDS   = 16;
    localparam logic [31:0] APP_VER = 32'h20240301;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    dp_ren = '0;
    logic [7:0]    dp_raddr = '0;
    logic [1023:0] dp_rdata;
    logic [1:0]    dp_wen = '0;
    logic [7:0]    dp_waddr = '0;
    logic [1023:0] dp_wdata = '0;
    logic          cfg_busy;

    int n_vec  = 0;
    int n_miss = 0;

    mqnic_app_cfg_ram_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) reg_bus ();

    mqnic_app_cfg_ram_ctrl #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (16),
        .BLOCK_SEL  (6'h0),
        .CH_COUNT   (2),
        .RAM_AWIDTH (4),
        .RAM_DWIDTH (512),
        .RD_DLY     (1),
        .APP_VER    (APP_VER)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .reg_bus  (reg_bus),
        .dp_ren   (dp_ren),
        .dp_raddr (dp_raddr),
        .dp_rdata (dp_rdata),
        .dp_wen   (dp_wen),
        .dp_waddr (dp_waddr),
        .dp_wdata (dp_wdata),
        .cfg_busy (cfg_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end #1 after a rising edge.
    task automatic reg_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, output logic ack);
        reg_bus.wr_addr = a;
        reg_bus.wr_data = d;
        reg_bus.wr_strb = s;
        reg_bus.wr_en   = 1'b1;
        @(posedge clk); #1;
        ack = reg_bus.wr_ack;
        reg_bus.wr_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic reg_rd(input logic [15:0] a, output logic [31:0] d, output logic ack);
        reg_bus.rd_addr = a;
        reg_bus.rd_en   = 1'b1;
        @(posedge clk); #1;
        ack = reg_bus.rd_ack;
        d   = reg_bus.rd_data;
        reg_bus.rd_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic dp_rd(input int ch, input logic [3:0] idx, output logic [511:0] d);
        dp_raddr[ch*4 +: 4] = idx;
        dp_ren[ch] = 1'b1;
        @(posedge clk); #1;
        dp_ren[ch] = 1'b0;
        d = dp_rdata[ch*512 +: 512];
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n = 0;
        while (cfg_busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 512'(cfg_busy), 512'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0]  d;
        logic         ack;
        logic [511:0] v, stg, stg2;
        int unsigned  cnt;

        reg_bus.wr_addr = '0; reg_bus.wr_data = '0; reg_bus.wr_strb = '0; reg_bus.wr_en = 1'b0;
        reg_bus.rd_addr = '0; reg_bus.rd_en = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 512'(cfg_busy), 512'(0));
        check("rst_rd_ack", 512'(reg_bus.rd_ack), 512'(0));
        rst_n = 1'b1;

        // ID registers and reset status
        reg_rd(16'h0000, d, ack); check("type", 512'(d), 512'(32'h0000C002)); check("type_ack", 512'(ack), 512'(1));
        reg_rd(16'h0004, d, ack); check("ver", 512'(d), 512'(APP_VER));
        reg_rd(16'h0008, d, ack); check("next_hdr", 512'(d), 512'(0));
        reg_rd(16'h000C, d, ack); check("info", 512'(d), 512'(32'h02040010));
        reg_rd(16'h0014, d, ack); check("status_rst", 512'(d), 512'(0));
        reg_rd(16'h0100, d, ack); check("stage_rst", 512'(d), 512'(0));

        // out-of-window: no ack
        reg_rd(16'h0404, d, ack); check("oow_rd_ack", 512'(ack), 512'(0));
        reg_wr(16'h0500, 32'hFFFFFFFF, 4'hF, ack); check("oow_wr_ack", 512'(ack), 512'(0));

        // reserved op is ignored: acked, no busy, no err
        reg_wr(16'h0010, 32'hC0010005, 4'hF, ack); check("rsvd_op_ack", 512'(ack), 512'(1));
        check("rsvd_op_busy", 512'(cfg_busy), 512'(0));
        reg_rd(16'h0014, d, ack); check("rsvd_op_status", 512'(d), 512'(0));

        // staging fill + byte-masked update
        for (int k = 0; k < WORDS; k++) begin
            stg[k*32 +: 32] = 32'(k) * 32'h11111111;
            reg_wr(16'h0100 + 16'(4*k), 32'(k) * 32'h11111111, 4'hF, ack);
        end
        check("stage_wr_ack", 512'(ack), 512'(1));
        reg_wr(16'h0104, 32'h0000AB00, 4'b0010, ack);
        stg[63:32] = 32'h1111AB11;
        reg_rd(16'h0104, d, ack); check("stage_strb", 512'(d), 512'(32'h1111AB11));
        reg_rd(16'h0120, d, ack); check("stage_w8", 512'(d), 512'(32'h88888888));
        reg_rd(16'h013C, d, ack); check("stage_w15", 512'(d), 512'(32'hFFFFFFFF));
        reg_rd(16'h0140, d, ack); check("stage_oor", 512'(d), 512'(0)); check("stage_oor_ack", 512'(ack), 512'(1));

        // commit ch1 idx5
        reg_wr(16'h0010, 32'h40010005, 4'hF, ack); check("commit_ack", 512'(ack), 512'(1));
        check("commit_busy", 512'(cfg_busy), 512'(1));
        wait_idle("commit_done");
        reg_rd(16'h0014, d, ack); check("commit_status", 512'(d), 512'(32'h00010005));
        dp_rd(1, 4'd5, v); check("commit_ram", v, stg);

        // clear staging, fetch it back
        for (int k = 0; k < WORDS; k++) reg_wr(16'h0100 + 16'(4*k), 32'h0, 4'hF, ack);
        reg_rd(16'h0108, d, ack); check("stage_clr", 512'(d), 512'(0));
        reg_wr(16'h0010, 32'h80010005, 4'hF, ack);
        wait_idle("fetch_done");
        for (int k = 0; k < WORDS; k++) begin
            reg_rd(16'h0100 + 16'(4*k), d, ack);
            v[k*32 +: 32] = d;
        end
        check("fetch_vec", v, stg);

        // read-first on a same-cycle dp write/read
        dp_waddr[7:4] = 4'd9; dp_wdata[1023:512] = {16{32'h0F0F0F0F}}; dp_wen[1] = 1'b1;
        @(posedge clk); #1;
        dp_wdata[1023:512] = {16{32'h12345678}}; dp_raddr[7:4] = 4'd9; dp_ren[1] = 1'b1;
        @(posedge clk); #1;
        dp_wen[1] = 1'b0; dp_ren[1] = 1'b0;
        check("read_first_old", dp_rdata[1023:512], {16{32'h0F0F0F0F}});
        dp_rd(1, 4'd9, v); check("read_first_new", v, {16{32'h12345678}});

        // contention: dp write to ch0 holds off the host commit
        for (int k = 0; k < WORDS; k++) begin
            stg2[k*32 +: 32] = 32'hA5000000 | 32'(k);
            reg_wr(16'h0100 + 16'(4*k), 32'hA5000000 | 32'(k), 4'hF, ack);
        end
        dp_waddr[3:0] = 4'd5; dp_wdata[511:0] = {16{32'hDEADBEEF}}; dp_wen[0] = 1'b1;
        reg_wr(16'h0010, 32'h40000005, 4'hF, ack); check("contend_ack", 512'(ack), 512'(1));
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (cfg_busy) cnt++;
        end
        check("contend_busy", 512'(cnt), 512'(10));
        dp_wen[0] = 1'b0;
        wait_idle("contend_done");
        dp_rd(0, 4'd5, v); check("contend_ram", v, stg2);

        // bad channel
        reg_wr(16'h0010, 32'h40030005, 4'hF, ack); check("badch_ack", 512'(ack), 512'(1));
        check("badch_busy", 512'(cfg_busy), 512'(0));
        reg_rd(16'h0014, d, ack); check("badch_status", 512'(d), 512'(32'h40000005));
        dp_rd(1, 4'd5, v); check("badch_ram", v, stg);
        reg_wr(16'h0014, 32'h40000000, 4'hF, ack);
        reg_rd(16'h0014, d, ack); check("err_clr1", 512'(d), 512'(32'h00000005));

        // command while busy: stalled commit ch1 idx7, then a rejected fetch ch1 idx5
        dp_waddr[7:4] = 4'd7; dp_wdata[1023:512] = {16{32'hCAFEF00D}}; dp_wen[1] = 1'b1;
        reg_wr(16'h0010, 32'h40010007, 4'hF, ack);
        reg_wr(16'h0010, 32'h80010005, 4'hF, ack); check("busy_cmd_ack", 512'(ack), 512'(1));
        reg_rd(16'h0014, d, ack); check("busy_status", 512'(d), 512'(32'hC0010007));
        dp_wen[1] = 1'b0;
        wait_idle("busy_done");
        reg_rd(16'h0014, d, ack); check("busy_err_held", 512'(d), 512'(32'h40010007));
        dp_rd(1, 4'd7, v); check("busy_commit_ram", v, stg2);
        reg_rd(16'h0100, d, ack); check("busy_no_fetch", 512'(d), 512'(32'hA5000000));
        reg_wr(16'h0014, 32'h40000000, 4'hF, ack);
        reg_rd(16'h0014, d, ack); check("err_clr2", 512'(d), 512'(32'h00010007));

        // async reset in the middle of a stalled fetch
        dp_waddr[3:0] = 4'd5; dp_wen[0] = 1'b1;
        reg_wr(16'h0010, 32'h80000005, 4'hF, ack);
        check("mid_fetch_busy", 512'(cfg_busy), 512'(1));
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 512'(cfg_busy), 512'(0));
        check("arst_wr_ack", 512'(reg_bus.wr_ack), 512'(0));
        check("arst_rd_ack", 512'(reg_bus.rd_ack), 512'(0));
        dp_wen[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        reg_rd(16'h0014, d, ack); check("arst_status", 512'(d), 512'(0));
        reg_rd(16'h0100, d, ack); check("arst_stage0", 512'(d), 512'(0));
        reg_rd(16'h013C, d, ack); check("arst_stage15", 512'(d), 512'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
